// File: rtl/mem_stage.sv
// mem_stage: memory-access stage that sits after the execute stage.
//
// It takes the EX result as the effective address, rs2 as store data, funct3
// and the memread/memwrite/memtoreg controls. Each aligned load or store runs
// one request/acknowledge transaction on the data-memory bus. The upstream
// pipeline is stalled until that transaction completes. Load data is aligned
// and extended, and the stage then produces the writeback value.
//
// Bus handshake: in IDLE the stage registers the address, byte enables, data
// and one strobe (o_DM_rd or o_DM_wr), then moves to BUSY. It holds all of
// them stable until i_DM_ack is sampled high. The strobe drops at that edge
// and the stage spends one DONE cycle before returning to IDLE. i_DM_ack is
// only looked at in BUSY.
//
// Optional feature macro: MEM_BUS_TIMEOUT_EN. When it is defined, a watchdog
// abandons a BUSY phase after TIMEOUT_CYCLES cycles without an ack and raises
// o_bus_err for the DONE cycle. When it is undefined, o_bus_err is tied to 0.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_res                 EX result / effective address
//   i_wr_data             store data (rs2)
//   i_f3                  funct3 (size in [1:0], unsigned load in [2])
//   i_memread, i_memwrite load / store request (store wins if both are set)
//   i_memtoreg            select load data for writeback
//   o_DM_addr/wdata/be    word-aligned address, lane-replicated data, enables
//   o_DM_rd, o_DM_wr      read / write strobes
//   i_DM_ack, i_DM_rdata  slave acknowledge and read data (valid with ack)
//   o_wb_data             writeback value
//   o_stall               hold the upstream pipeline
//   o_misaligned          misaligned access (no bus transaction issued)
//   o_bus_err             bus timeout flag (feature build only)
module mem_stage #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_res,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [2:0]      i_f3,
    input  logic            i_memread,
    input  logic            i_memwrite,
    input  logic            i_memtoreg,
    output logic [XLEN-1:0] o_DM_addr,
    output logic [XLEN-1:0] o_DM_wdata,
    output logic [3:0]      o_DM_be,
    output logic            o_DM_rd,
    output logic            o_DM_wr,
    input  logic            i_DM_ack,
    input  logic [XLEN-1:0] i_DM_rdata,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_stall,
    output logic            o_misaligned,
    output logic            o_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [XLEN-1:0]   r_DM_addr;
    logic [XLEN-1:0]   r_DM_wdata;
    logic [3:0]        r_DM_be;
    logic              r_DM_rd;
    logic              r_DM_wr;
    logic [XLEN-1:0]   r_rdata;
    logic [1:0]        r_a_lat;
    logic [2:0]        r_f3_lat;

    logic              w_acc;
    logic              w_half;
    logic              w_word;
    logic              w_mis;
    logic              w_start;
    logic              w_timeout;
    logic [XLEN-1:0]   w_shift;
    logic [XLEN-1:0]   w_load;

    assign w_acc   = i_memread | i_memwrite;
    assign w_half  = (i_f3[1:0] == 2'b01);
    assign w_word  = i_f3[1];
    assign w_mis   = w_acc & ((w_half & i_res[0]) | (w_word & (|i_res[1:0])));
    assign w_start = (r_state == S_IDLE) & w_acc & ~w_mis;

`ifdef MEM_BUS_TIMEOUT_EN
    // Counts BUSY cycles without an ack. Fires on the cycle that would bring
    // the count up to TIMEOUT_CYCLES. An ack in that same cycle still wins.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_cnt;
    logic       r_bus_err;

    assign w_timeout = (r_state == S_BUSY) & ~i_DM_ack & (r_cnt == TMO_LAST);
    assign o_bus_err = r_bus_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_start)
                r_cnt <= '0;
            else if (r_state == S_BUSY && !i_DM_ack)
                r_cnt <= r_cnt + 8'd1;
            r_bus_err <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next state and stall
    always_comb begin
        w_next  = r_state;
        o_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_stall = w_start;
                if (w_start)
                    w_next = S_BUSY;
            end
            S_BUSY: begin
                o_stall = 1'b1;
                if (i_DM_ack || w_timeout)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus request registers and read-data capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_DM_addr  <= '0;
            r_DM_wdata <= '0;
            r_DM_be    <= '0;
            r_DM_rd    <= 1'b0;
            r_DM_wr    <= 1'b0;
            r_rdata    <= '0;
            r_a_lat    <= '0;
            r_f3_lat   <= '0;
        end else begin
            if (w_start) begin
                r_DM_addr <= {i_res[XLEN-1:2], 2'b00};
                if (w_word) begin
                    r_DM_be    <= 4'b1111;
                    r_DM_wdata <= i_wr_data;
                end else if (w_half) begin
                    r_DM_be    <= 4'b0011 << {i_res[1], 1'b0};
                    r_DM_wdata <= {2{i_wr_data[15:0]}};
                end else begin
                    r_DM_be    <= 4'b0001 << i_res[1:0];
                    r_DM_wdata <= {4{i_wr_data[7:0]}};
                end
                r_DM_wr  <= i_memwrite;
                r_DM_rd  <= ~i_memwrite;
                r_a_lat  <= i_res[1:0];
                r_f3_lat <= i_f3;
            end else if (r_state == S_BUSY) begin
                if (i_DM_ack) begin
                    r_DM_rd <= 1'b0;
                    r_DM_wr <= 1'b0;
                    if (r_DM_rd)
                        r_rdata <= i_DM_rdata;
                end else if (w_timeout) begin
                    r_DM_rd <= 1'b0;
                    r_DM_wr <= 1'b0;
                    r_rdata <= '0;
                end
            end
        end
    end

    assign o_DM_addr    = r_DM_addr;
    assign o_DM_wdata   = r_DM_wdata;
    assign o_DM_be      = r_DM_be;
    assign o_DM_rd      = r_DM_rd;
    assign o_DM_wr      = r_DM_wr;
    assign o_misaligned = w_mis;

    // Bring the addressed lane down to bit 0, then extend it to full width
    assign w_shift = r_rdata >> {r_a_lat, 3'b000};

    always_comb begin
        w_load = w_shift;
        case (r_f3_lat[1:0])
            2'b00: w_load = r_f3_lat[2] ? {24'd0, w_shift[7:0]}
                                        : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01: w_load = r_f3_lat[2] ? {16'd0, w_shift[15:0]}
                                        : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    assign o_wb_data = i_memtoreg ? w_load : i_res;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage. A transaction-level model predicts, for every cycle,
// what stall, strobes, bus fields and writeback must be. A single compare
// process checks them on the falling clock edge.
module tb_mem_stage;

    localparam int TMO = 6;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_res;
    logic [31:0] i_wr_data;
    logic [2:0]  i_f3;
    logic        i_memread;
    logic        i_memwrite;
    logic        i_memtoreg;
    logic [31:0] o_DM_addr;
    logic [31:0] o_DM_wdata;
    logic [3:0]  o_DM_be;
    logic        o_DM_rd;
    logic        o_DM_wr;
    logic        i_DM_ack;
    logic [31:0] i_DM_rdata;
    logic [31:0] o_wb_data;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_bus_err;

    mem_stage #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_res(i_res), .i_wr_data(i_wr_data),
        .i_f3(i_f3), .i_memread(i_memread), .i_memwrite(i_memwrite),
        .i_memtoreg(i_memtoreg), .o_DM_addr(o_DM_addr), .o_DM_wdata(o_DM_wdata),
        .o_DM_be(o_DM_be), .o_DM_rd(o_DM_rd), .o_DM_wr(o_DM_wr),
        .i_DM_ack(i_DM_ack), .i_DM_rdata(i_DM_rdata), .o_wb_data(o_wb_data),
        .o_stall(o_stall), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected values for the current cycle
    logic        chk_en = 1'b0;
    logic        chk_bus, chk_wb;
    logic        e_stall, e_rd, e_wr, e_mis, e_err;
    logic [31:0] e_addr, e_wdata, e_wb;
    logic [3:0]  e_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("stall",      32'(o_stall),      32'(e_stall));
            chk("rd",         32'(o_DM_rd),      32'(e_rd));
            chk("wr",         32'(o_DM_wr),      32'(e_wr));
            chk("misaligned", 32'(o_misaligned), 32'(e_mis));
            chk("bus_err",    32'(o_bus_err),    32'(e_err));
            if (chk_bus) begin
                chk("addr",  o_DM_addr,       e_addr);
                chk("be",    32'(o_DM_be),    32'(e_be));
                chk("wdata", o_DM_wdata,      e_wdata);
            end
            if (chk_wb)
                chk("wb_data", o_wb_data, e_wb);
        end
    end

    // ---------------- behavioural model ----------------
    function automatic logic m_mis(input logic ld, input logic st,
                                   input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (!(ld || st)) return 1'b0;
        sz = f3[1] ? 4 : (f3[0] ? 2 : 1);
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
        int v;
        if (f3[1])      v = 15;
        else if (f3[0]) v = 3 << off;
        else            v = 1 << off;
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1]) return d;
        if (f3[0]) return (d & 32'hFFFF) * 32'h00010001;
        return (d & 32'hFF) * 32'h01010101;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * off);
        if (f3[1]) return v;
        if (f3[0]) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = v & 32'hFF;
            if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // One instruction: IDLE cycle, then (if aligned access) wt wait cycles,
    // the ack cycle and the DONE cycle. tmo = never ack (watchdog build).
    task automatic do_op(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3, input logic m2r,
                         input int wt, input logic [31:0] rdat,
                         input logic use_lit, input logic [31:0] lit, input logic tmo);
        logic acc, mis;
        i_res = a; i_wr_data = d; i_f3 = f3;
        i_memread = ld; i_memwrite = st; i_memtoreg = m2r;
        i_DM_ack = 1'($urandom_range(0, 1));
        i_DM_rdata = $urandom;
        acc = ld | st;
        mis = m_mis(ld, st, f3, a);
        e_stall = acc & ~mis; e_rd = 1'b0; e_wr = 1'b0; e_mis = mis; e_err = 1'b0;
        chk_bus = 1'b0; chk_wb = ~m2r; e_wb = a;
        step();
        if (!acc || mis) return;
        e_rd = ~st; e_wr = st; e_stall = 1'b1;
        e_addr = {a[31:2], 2'b00}; e_be = m_be(f3, a[1:0]); e_wdata = m_wdata(f3, d);
        chk_bus = 1'b1;
        for (int k = 0; k <= wt; k++) begin
            i_DM_ack   = (k == wt) && !tmo;
            i_DM_rdata = (k == wt) ? rdat : $urandom;
            step();
        end
        e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0; chk_bus = 1'b0; chk_wb = 1'b1;
        e_err = tmo;
        i_DM_ack = 1'($urandom_range(0, 1));
        i_DM_rdata = $urandom;
        if (m2r)
            e_wb = use_lit ? lit : (tmo ? 32'd0 : m_load(f3, a[1:0], rdat));
        else
            e_wb = a;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int kind;
        logic ld, st, m2r;
        logic [31:0] a;

        i_rst = 1'b1; i_res = '0; i_wr_data = '0; i_f3 = '0;
        i_memread = 1'b0; i_memwrite = 1'b0; i_memtoreg = 1'b0;
        i_DM_ack = 1'b0; i_DM_rdata = '0;
        repeat (2) step();

        // Reset state: everything zero, read register zero
        e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_mis = 1'b0; e_err = 1'b0;
        e_addr = '0; e_be = '0; e_wdata = '0; e_wb = '0;
        chk_bus = 1'b1; chk_wb = 1'b1; chk_en = 1'b1;
        step();
        i_rst = 1'b0;
        i_memtoreg = 1'b1; i_f3 = 3'b010; i_res = 32'h1234_5678;
        step();

        // Directed cases with hand-computed writeback
        do_op(1, 0, 32'h100, 32'h0, 3'b010, 1, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0);
        do_op(1, 0, 32'h103, 32'h0, 3'b000, 1, 1, 32'h80123456, 1, 32'hFFFFFF80, 0);
        do_op(1, 0, 32'h103, 32'h0, 3'b100, 1, 0, 32'h80123456, 1, 32'h00000080, 0);
        do_op(1, 0, 32'h102, 32'h0, 3'b101, 1, 2, 32'hBEEF1234, 1, 32'h0000BEEF, 0);
        do_op(0, 1, 32'h201, 32'hA5, 3'b000, 0, 4, 32'h0, 0, 32'h0, 0);
        do_op(0, 1, 32'h301, 32'hCAFE, 3'b001, 0, 0, 32'h0, 0, 32'h0, 0);
        do_op(1, 0, 32'h402, 32'h0, 3'b010, 0, 0, 32'h0, 0, 32'h0, 0);
        do_op(1, 1, 32'h20C, 32'h11223344, 3'b010, 0, 1, 32'h0, 0, 32'h0, 0);

        // Reset while BUSY, then a late ack that must be ignored
        i_res = 32'h100; i_wr_data = '0; i_f3 = 3'b010;
        i_memread = 1'b1; i_memwrite = 1'b0; i_memtoreg = 1'b0; i_DM_ack = 1'b0;
        e_stall = 1'b1; e_rd = 1'b0; e_wr = 1'b0; e_mis = 1'b0;
        chk_bus = 1'b0; chk_wb = 1'b1; e_wb = 32'h100;
        step();
        e_rd = 1'b1; chk_bus = 1'b1;
        e_addr = 32'h100; e_be = 4'b1111; e_wdata = 32'h0;
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0; i_memread = 1'b0; i_res = 32'h55; i_DM_ack = 1'b1;
        e_stall = 1'b0; e_rd = 1'b0; chk_bus = 1'b0; e_wb = 32'h55;
        step();
        i_DM_ack = 1'b0;
        step();
        do_op(1, 0, 32'h104, 32'h0, 3'b010, 1, 0, 32'h0BADF00D, 1, 32'h0BADF00D, 0);

`ifdef MEM_BUS_TIMEOUT_EN
        do_op(1, 0, 32'h500, 32'h0, 3'b010, 1, TMO - 1, 32'hFFFFFFFF, 1, 32'h0, 1);
        do_op(1, 0, 32'h504, 32'h0, 3'b010, 1, TMO - 1, 32'h13579BDF, 1, 32'h13579BDF, 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 3);
            ld   = (kind == 1) || (kind == 3);
            st   = (kind >= 2);
            a    = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            m2r  = (ld && !st) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_op(ld, st, a, $urandom, 3'($urandom), m2r, $urandom_range(0, TMO - 2),
                  $urandom, 0, 32'h0, 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the EX result as the effective address, the rs2 value as store data, funct3, and the memread/memwrite/memtoreg controls.
- Runs one request/acknowledge transaction per load or store on the data-memory bus, and stalls the pipeline until that transaction completes.
- Aligns and extends load data, then produces the writeback value.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 255, bus watchdog limit in cycles; used only when MEM_BUS_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_res  in  XLEN  EX result; effective address for memory ops, pass-through value otherwise.
- i_wr_data  in  XLEN  store data (rs2).
- i_f3  in  3  funct3 of the instruction.
- i_memread  in  1  load.
- i_memwrite  in  1  store.
- i_memtoreg  in  1  select load data for writeback.
- o_DM_addr  out  XLEN  word-aligned bus address.
- o_DM_wdata  out  XLEN  lane-replicated store data.
- o_DM_be  out  4  byte enables.
- o_DM_rd  out  1  read strobe.
- o_DM_wr  out  1  write strobe.
- i_DM_ack  in  1  slave acknowledge.
- i_DM_rdata  in  XLEN  read data, valid with ack.
- o_wb_data  out  XLEN  writeback value.
- o_stall  out  1  hold the upstream pipeline.
- o_misaligned  out  1  misaligned access flag.
- o_bus_err  out  1  bus timeout flag (feature only).

Behaviour:
- Access: acc = i_memread | i_memwrite. A store takes priority when both are set (treated as a store).
- Access size from i_f3[1:0]:
  - 00 byte, 01 halfword, 1x word.
  - Loads zero-extend when i_f3[2]=1, sign-extend when i_f3[2]=0.
- Misalignment:
  - mis = acc & ((half & a[0]) | (word & |a[1:0])), where a = i_res.
  - o_misaligned = mis, combinational.
  - A misaligned access issues no bus transaction and does not stall. The exception unit handles it.
- FSM states: IDLE, BUSY, DONE. Reset drives IDLE, o_DM_rd=0, o_DM_wr=0, o_DM_addr=0, o_DM_wdata=0, o_DM_be=0, read register=0, o_bus_err=0.
- IDLE:
  - If acc & !mis: register the following, then go to BUSY.
    - o_DM_addr = {a[31:2],2'b00}.
    - o_DM_be: byte 0001<<a[1:0]; half 0011<<{a[1],1'b0}; word 1111.
    - o_DM_wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
    - Strobe: o_DM_wr=1 for a store, else o_DM_rd=1.
  - Also latch a[1:0] and i_f3.
- BUSY:
  - Strobes and address/data/be are held stable until i_DM_ack=1.
  - In the ack cycle: capture i_DM_rdata into the read register, clear strobes at the next edge, go to DONE.
  - A 1-cycle-latency slave can ack in the first BUSY cycle.
- DONE: lasts one cycle, then goes to IDLE unconditionally.
- o_stall (combinational) = (IDLE & acc & !mis) | BUSY. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Minimum load/store occupancy is 3 cycles: IDLE, BUSY, DONE.
- Load result:
  - Shift the read register right by 8*a_lat[1:0].
  - Extend the low byte or halfword per f3_lat.
- o_wb_data = i_memtoreg ? load_result : i_res. This is combinational and valid in DONE for loads and in any cycle for non-memory ops.
- i_DM_ack is ignored in IDLE and DONE.
- i_DM_rdata is ignored for stores.
- Reset mid-transaction: strobes drop at that edge, state goes to IDLE, and any later ack is ignored.

Optional Feature:
- MEM_BUS_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES without ack: drop strobes, go to DONE, and assert o_bus_err=1 for the DONE cycle only. The read register is forced to 0.
  - An ack in the same cycle as the limit wins: normal completion, no error.
- Not defined: no counter, o_bus_err tied to 0, and BUSY waits indefinitely.

Test Plan:
- LW at a=0x100, ack in 1st BUSY cycle, rdata=0xDEADBEEF, memtoreg=1:
  - o_DM_rd=1 with o_DM_addr=0x100 and be=1111.
  - o_stall high for 2 cycles.
  - o_wb_data=0xDEADBEEF in DONE.
- LB at a=0x103 with rdata=0x80XXXXXX → 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at a=0x102 with rdata=0xBEEF1234 → 0x0000BEEF.
- SB a=0x201, d=0x000000A5:
  - be=0010, wdata=0xA5A5A5A5, o_DM_wr=1.
  - Slave acks after 4 wait cycles → o_stall high 6 cycles, strobe stable throughout.
- SH at a=0x301 and LW at a=0x402:
  - o_misaligned=1, o_stall=0, no strobe asserted.
- Reset asserted in BUSY:
  - Next cycle o_DM_rd=0 and state IDLE.
  - A late ack is ignored; the following LW completes normally.
- With MEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → strobes drop after 4 BUSY cycles, o_bus_err=1 for exactly one cycle, o_wb_data=0.
